// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch stage: control-flow opcodes,
// 2-bit saturating counter type and its update helpers.
package cpu_pkg;

  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  // BRANCH, JAL and JALR all share these three upper opcode bits
  localparam logic [2:0] OP_CTRL_HI = 3'b110;

  typedef logic [1:0] ctr2_t;

  localparam ctr2_t CTR_SNT = 2'b00;
  localparam ctr2_t CTR_WNT = 2'b01;
  localparam ctr2_t CTR_WT  = 2'b10;
  localparam ctr2_t CTR_ST  = 2'b11;

  // Saturating step toward the resolved direction; never wraps.
  function automatic ctr2_t ctr_next(input ctr2_t ctr, input logic taken);
    ctr2_t nxt;
    unique case (ctr)
      CTR_SNT: nxt = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: nxt = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  nxt = taken ? CTR_ST  : CTR_WNT;
      default: nxt = taken ? CTR_ST  : CTR_WT;
    endcase
    return nxt;
  endfunction

  // Initial confidence for a freshly allocated entry: unconditional
  // jumps start strongly taken, conditional branches weakly taken.
  function automatic ctr2_t alloc_ctr(input logic [6:0] op);
    ctr2_t c;
    unique case (op)
      OP_JAL, OP_JALR: c = CTR_ST;
      OP_BRANCH:       c = CTR_WT;
      default:         c = CTR_WT;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped branch target buffer: valid/tag/target/counter arrays with
// one combinational lookup port and one synchronous train port.
// The train port does its own hit check against the stored entry, so the
// lookup port always returns the pre-update contents (no bypass).
module btb_table
  import cpu_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = 32 - IDX_W - 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  // lookup port
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_target,
  output ctr2_t            rd_ctr,
  // train port
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic [TAG_W-1:0] upd_tag,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  ctr2_t            upd_alloc_ctr
);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  ctr2_t              ctr_q    [ENTRIES];

  logic upd_hit;
  logic upd_alloc;

  // Lookup is a plain array read of the current contents
  always_comb begin
    rd_valid  = valid_q[rd_idx];
    rd_tag    = tag_q[rd_idx];
    rd_target = target_q[rd_idx];
    rd_ctr    = ctr_q[rd_idx];
  end

  // Classify the training event against the stored entry
  always_comb begin
    upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    upd_alloc = upd_en && !upd_hit && upd_taken;
  end

  // Valid bits are the only state that reset clears
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (upd_alloc) begin
      valid_q[upd_idx] <= 1'b1;
    end
  end

  // Payload arrays: train a hit, or overwrite the slot on a taken miss
  always_ff @(posedge clk_i) begin
    if (upd_en && upd_hit) begin
      ctr_q[upd_idx] <= ctr_next(ctr_q[upd_idx], upd_taken);
      if (upd_taken) begin
        target_q[upd_idx] <= upd_target;
      end
    end else if (upd_alloc) begin
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= upd_target;
      ctr_q[upd_idx]    <= upd_alloc_ctr;
    end
  end

endmodule

// File: rtl/twobit_branch_predictor.sv
// IF-stage next-PC generator. Holds the fetch PC, predicts taken control
// flow from a direct-mapped BTB with 2-bit counters, and is redirected and
// trained by the resolved EX-stage instruction.
// There is no valid/ready handshake: every input is consumed on every
// posedge, and a redirect reaches pc_IF one cycle later.
module twobit_branch_predictor
  import cpu_pkg::*;
#(
  parameter int          ENTRIES  = 64,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_PC,
  input  logic        comp_o,
  input  logic [31:0] PC_jump_EX,
  input  logic [31:0] pc_EX,
  input  logic [6:0]  op_ex,
  input  logic        PCSel_EX,
  output logic [31:0] pc_IF,
  output logic        pred_taken,
  output logic [31:0] pred_target
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;

  logic [31:0]      pc_q;
  logic [31:0]      pc_d;

  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_target;
  ctr2_t            rd_ctr;

  logic             upd_en;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  ctr2_t            upd_alloc_ctr;

  // Byte offset of pc_EX carries no information for the BTB
  logic unused_pc_ex;
  assign unused_pc_ex = ^pc_EX[1:0];

  btb_table #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W),
    .TAG_W   (TAG_W)
  ) u_btb (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .rd_idx        (if_idx),
    .rd_valid      (rd_valid),
    .rd_tag        (rd_tag),
    .rd_target     (rd_target),
    .rd_ctr        (rd_ctr),
    .upd_en        (upd_en),
    .upd_idx       (upd_idx),
    .upd_tag       (upd_tag),
    .upd_taken     (PCSel_EX),
    .upd_target    (PC_jump_EX),
    .upd_alloc_ctr (upd_alloc_ctr)
  );

  // Lookup for the current fetch PC; counter MSB is the direction
  always_comb begin
    if_idx      = pc_q[IDX_W+1:2];
    if_tag      = pc_q[31:IDX_W+2];
    pred_taken  = rd_valid && (rd_tag == if_tag) && rd_ctr[1];
    pred_target = rd_target;
  end

  // Training decode: any control-flow opcode in EX trains the table
  always_comb begin
    upd_en        = (op_ex[6:4] == OP_CTRL_HI);
    upd_idx       = pc_EX[IDX_W+1:2];
    upd_tag       = pc_EX[31:IDX_W+2];
    upd_alloc_ctr = alloc_ctr(op_ex);
  end

  // Next-PC select: mispredict redirect beats stall beats prediction
  always_comb begin
    if (comp_o) begin
      pc_d = PC_jump_EX;
    end else if (stall_PC) begin
      pc_d = pc_q;
    end else if (pred_taken) begin
      pc_d = pred_target;
    end else begin
      pc_d = pc_q + 32'd4;
    end
  end

  // Fetch PC register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_IF = pc_q;

endmodule
